uart_gain_transmitter: RTL

UART transmitter that reports the equalizer's current band-gain settings back to the host; the return path of the gain-receive link. On a request pulse it snapshots the three 8-bit gains and serialises a fixed 5-byte frame (sync, low, mid, high, checksum) as 8N1, LSB first. It is paced by the same `baud_on` tick the receive side uses and sits beside the UART receiver in the equalizer top level.

---
 rtl/eq_pkg.sv | 26 ++
 rtl/uart_tx_byte.sv | 98 +++++++++
 rtl/uart_gain_transmitter.sv | 85 ++++++++
 3 files changed

// File: rtl/eq_pkg.sv
// Shared equalizer definitions: band/gain geometry, the gain-report frame
// layout and the transmitter FSM encoding.
package eq_pkg;

  localparam int NUM_BANDS   = 3;
  localparam int GAIN_W      = 8;
  localparam int FRAME_BYTES = 5;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Modulo-256 sum of the three band gains; the sync byte is not included.
  function automatic logic [GAIN_W-1:0] gain_checksum(
    input logic [GAIN_W-1:0] g0,
    input logic [GAIN_W-1:0] g1,
    input logic [GAIN_W-1:0] g2
  );
    return g0 + g1 + g2;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 single-byte serialiser, LSB first, one bit per OVERSAMPLE baud_on ticks.
// Bytes can be chained back-to-back by asserting start as the stop bit ends.
module uart_tx_byte
  import eq_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_on,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       byte_end,
  output logic [1:0] state
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);

  localparam logic [1:0] S_IDLE  = TX_IDLE;
  localparam logic [1:0] S_START = TX_START;
  localparam logic [1:0] S_DATA  = TX_DATA;
  localparam logic [1:0] S_STOP  = TX_STOP;

  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;

  // Handshake: start/data are taken when ready is high (idle) or in the cycle
  // byte_end is high (stop bit finishing); at any other time start is ignored.
  assign bit_end  = baud_on && (tick_cnt == TICK_LAST) && (state != S_IDLE);
  assign byte_end = bit_end && (state == S_STOP);
  assign ready    = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      if (state != S_IDLE && baud_on) begin
        tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_START;
            shreg    <= data;
            tick_cnt <= '0;
            tx       <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            bit_idx <= '0;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (start) begin
              state <= S_START;
              shreg <= data;
              tx    <= 1'b0;
            end else begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_gain_transmitter.sv
// Gain report transmitter: on report_req snapshots the three band gains and
// sends A5, gain[0], gain[1], gain[2], checksum as one gapless 8N1 frame.
module uart_gain_transmitter
  import eq_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud_on,
  input  logic              report_req,
  input  logic [GAIN_W-1:0] gain [0:NUM_BANDS-1],
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state
);

  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

  logic [GAIN_W-1:0] snap [0:NUM_BANDS-1];
  logic [2:0]        byte_idx;
  logic              accept;
  logic              byte_start;
  logic              byte_end;
  logic              ready;
  logic [7:0]        next_byte;
  logic [7:0]        byte_data;

  // A request coinciding with done is dropped even though the serialiser is
  // already idle in that cycle.
  assign accept     = ready && report_req && !done;
  assign byte_start = accept || (byte_end && (byte_idx != LAST_BYTE));
  assign byte_data  = accept ? SYNC_BYTE : next_byte;

  // Byte that follows the one currently on the line.
  always_comb begin
    next_byte = SYNC_BYTE;
    case (byte_idx)
      3'd0:    next_byte = snap[0];
      3'd1:    next_byte = snap[1];
      3'd2:    next_byte = snap[2];
      3'd3:    next_byte = gain_checksum(snap[0], snap[1], snap[2]);
      default: next_byte = SYNC_BYTE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BANDS; i++) snap[i] <= '0;
      byte_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= byte_end && (byte_idx == LAST_BYTE);
      if (accept) begin
        for (int i = 0; i < NUM_BANDS; i++) snap[i] <= gain[i];
        byte_idx <= '0;
        busy     <= 1'b1;
      end else if (byte_end) begin
        if (byte_idx == LAST_BYTE) begin
          byte_idx <= '0;
          busy     <= 1'b0;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

  uart_tx_byte #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tx_byte (
    .clk      (clk),
    .reset    (reset),
    .baud_on  (baud_on),
    .start    (byte_start),
    .data     (byte_data),
    .tx       (tx),
    .ready    (ready),
    .byte_end (byte_end),
    .state    (state)
  );

endmodule
